// File: rtl/mu0_timer_pkg.sv
// Shared register map and CTRL layout for the MU0 countdown timer.
package mu0_timer_pkg;

   // Word offsets of the four timer registers relative to BASE_ADDR.
   typedef enum logic [1:0] {
      OFS_CTRL   = 2'd0,
      OFS_LOAD   = 2'd1,
      OFS_COUNT  = 2'd2,
      OFS_STATUS = 2'd3
   } reg_ofs_e;

   localparam int EN_BIT          = 0;
   localparam int AUTO_BIT        = 1;
   localparam int IE_BIT          = 2;
   localparam int STATUS_FLAG_BIT = 0;

   // CTRL bits packed so that field positions match EN_BIT/AUTO_BIT/IE_BIT.
   typedef struct packed {
      logic ie;
      logic auto_rl;
      logic en;
   } ctrl_t;

   // Zero-extend CTRL to a bus word; unused bits read as 0.
   function automatic logic [15:0] ctrl_word(input ctrl_t c);
      return {13'd0, c};
   endfunction

endpackage

// File: rtl/mu0_prescaler.sv
// Divides Clk down to a one-cycle tick every PRESCALE cycles while running.
module mu0_prescaler #(
   parameter int PRESCALE = 10000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] pre;

   assign tick = run && (pre == LAST);

   // Phase counter: held at 0 when stopped or cleared, wraps after the tick.
   always_ff @(posedge Clk) begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      if (Reset || clr || !run || tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 16'd1;
      end
   end

endmodule

// File: rtl/mu0_timer.sv
// Memory-mapped countdown timer on the MU0 Addr/Dout/Wr bus with registered readback.
module mu0_timer
   import mu0_timer_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = 12'hFF0,
   parameter int          PRESCALE  = 10000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [11:0] Addr,
   input  logic [15:0] Dout,
   input  logic        Wr,
   output logic [15:0] Rd_data,
   output logic        Hit,
   output logic        Expired,
   output logic        Irq
);

   ctrl_t       ctrl, ctrl_nxt;
   logic [15:0] load_r, load_nxt;
   logic [15:0] count_r, count_nxt;
   logic        flag, flag_nxt;
   logic [11:0] ofs_full;
   logic        hit_c;
   reg_ofs_e    ofs;
   logic        wr_ctrl, wr_load, wr_count, wr_status;
   logic        pre_clr, tick, expire;
   logic [15:0] rd_c;

   // Address decode: four consecutive words starting at BASE_ADDR.
   assign ofs_full  = Addr - BASE_ADDR;
   assign hit_c     = (ofs_full < 12'd4);
   assign ofs       = reg_ofs_e'(ofs_full[1:0]);
   assign wr_ctrl   = Wr && hit_c && (ofs == OFS_CTRL);
   assign wr_load   = Wr && hit_c && (ofs == OFS_LOAD);
   assign wr_count  = Wr && hit_c && (ofs == OFS_COUNT);
   assign wr_status = Wr && hit_c && (ofs == OFS_STATUS);

   // Restart the tick phase when counting is (re)enabled or COUNT is rewritten.
   assign pre_clr = (wr_ctrl && Dout[EN_BIT]) || wr_count;

   mu0_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (pre_clr),
      .run   (ctrl.en),
      .tick  (tick)
   );

   assign expire = tick && (count_r == 16'd1);

   // Register-file next state: tick update first, CPU writes then override it.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      ctrl_nxt  = ctrl;
      load_nxt  = load_r;
      count_nxt = count_r;
      flag_nxt  = flag;
      if (tick) begin
         if (count_r > 16'd1) begin
            count_nxt = count_r - 16'd1;
         end else if (expire) begin
            if (ctrl.auto_rl) begin
               count_nxt = load_r;
            end else begin
               count_nxt   = '0;
               ctrl_nxt.en = 1'b0;
            end
         end
      end
      if (wr_ctrl)  ctrl_nxt  = ctrl_t'(Dout[IE_BIT:EN_BIT]);
      if (wr_load)  load_nxt  = Dout;
      if (wr_count) count_nxt = Dout;
      if (wr_status && Dout[STATUS_FLAG_BIT]) flag_nxt = 1'b0;
      // Expiry wins over a same-cycle write-1-to-clear.
      if (expire)   flag_nxt  = 1'b1;
   end

   // Readback mux over the pre-write register values.
   always_comb begin
      rd_c = '0;
      case (ofs)
         OFS_CTRL:   rd_c = ctrl_word(ctrl);
         OFS_LOAD:   rd_c = load_r;
         OFS_COUNT:  rd_c = count_r;
         OFS_STATUS: rd_c = {15'd0, flag};
         default:    rd_c = '0;
      endcase
      if (!hit_c) rd_c = '0;
   end

   // Timer state, expiry pulse and one-cycle-latency read port.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ctrl    <= '0;
         load_r  <= '0;
         count_r <= '0;
         flag    <= 1'b0;
         Expired <= 1'b0;
         Rd_data <= '0;
         Hit     <= 1'b0;
      end else begin
         ctrl    <= ctrl_nxt;
         load_r  <= load_nxt;
         count_r <= count_nxt;
         flag    <= flag_nxt;
         Expired <= expire;
         Rd_data <= rd_c;
         Hit     <= hit_c;
      end
   end

   assign Irq = flag && ctrl.ie;

endmodule
